rx_gate_sequencer: RTL and testbench

- Timing controller for the receive capture path.
- On each rising edge of the externally synchronized radar trigger, it waits a programmable number of decimator strobes, then asserts the receive-buffer gate for exactly a programmed number of strobes.
- Configured over the serial settings bus. Drives the gate_enable input of the RX buffer in place of the raw synchronized trigger.
- Provides status readback: window counter and missed-trigger flag.

---
 rtl/rx_gate_sequencer.sv | 178 +++++++++++++++++
 tb/tb_rx_gate_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_gate_sequencer.sv
// rx_gate_sequencer
//
// Receive-capture timing controller. Each rising edge of the synchronized
// radar trigger starts a window: wait delay_reg decimator strobes, then hold
// gate_out high for length_reg strobes. gate_out drives the RX buffer gate
// in place of the raw trigger.
//
// Ports:
//   clock          DSP clock (clk64 domain)
//   reset_n        asynchronous active-low reset
//   serial_strobe  settings-bus write strobe
//   serial_addr    settings-bus address (7 bits)
//   serial_data    settings-bus data (32 bits)
//   trigger        synchronized external trigger (level)
//   strobe         decimator strobe, single cycle per output sample
//   gate_out       capture gate to the RX buffer
//   busy           high while a window (delay or capture) is in progress
//   missed_trigger sticky: a trigger rise arrived while busy
//   window_count   number of completed windows (wraps at 16 bits)
//   status         {14'b0, enable, missed_trigger, window_count}
//   state_dbg      current FSM state (0 = IDLE, 1 = DELAY, 2 = CAPTURE)
//
// Settings bus handshake: a write is a single cycle with serial_strobe high;
// serial_addr/serial_data are valid only in that cycle and the write is
// always accepted (there is no ready/backpressure).

module rx_gate_sequencer #(
    parameter logic [6:0] ADDR_DELAY  = 7'd64,
    parameter logic [6:0] ADDR_LENGTH = 7'd65,
    parameter logic [6:0] ADDR_CTRL   = 7'd66
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        serial_strobe,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        trigger,
    input  logic        strobe,
    output logic        gate_out,
    output logic        busy,
    output logic        missed_trigger,
    output logic [15:0] window_count,
    output logic [31:0] status,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [15:0] delay_reg, length_reg;
    logic        enable;
    logic        trig_q;
    logic [15:0] cnt, cnt_next;
    logic [15:0] len_lat, len_lat_next;
    logic        missed_next;
    logic [15:0] window_count_next;
    logic        window_done;

    logic wr_delay, wr_length, wr_ctrl, clear, trig_rise;
    logic unused_data;

    assign wr_delay    = serial_strobe && (serial_addr == ADDR_DELAY);
    assign wr_length   = serial_strobe && (serial_addr == ADDR_LENGTH);
    assign wr_ctrl     = serial_strobe && (serial_addr == ADDR_CTRL);
    assign clear       = wr_ctrl && serial_data[1];
    assign trig_rise   = trigger && !trig_q;
    assign unused_data = ^serial_data[31:16];

    // Configuration registers and trigger history.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            delay_reg  <= 16'd0;
            length_reg <= 16'd0;
            enable     <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            trig_q <= trigger;
            if (wr_delay)  delay_reg  <= serial_data[15:0];
            if (wr_length) length_reg <= serial_data[15:0];
            if (wr_ctrl)   enable     <= serial_data[0];
        end
    end

    // Next-state logic. The strobe sampled on the edge that enters a state
    // is seen while still in the previous state, so it is never counted
    // by the new state.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        len_lat_next = len_lat;
        window_done  = 1'b0;
        case (state)
            IDLE: begin
                if (trig_rise && enable && (length_reg != 16'd0)) begin
                    // Both registers are captured here so later writes
                    // cannot disturb the window already in flight.
                    len_lat_next = length_reg;
                    if (delay_reg == 16'd0) begin
                        state_next = CAPTURE;
                        cnt_next   = length_reg;
                    end else begin
                        state_next = DELAY;
                        cnt_next   = delay_reg;
                    end
                end
            end
            DELAY: begin
                if (!enable) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else if (strobe) begin
                    if (cnt == 16'd1) begin
                        state_next = CAPTURE;
                        cnt_next   = len_lat;
                    end else begin
                        cnt_next = cnt - 16'd1;
                    end
                end
            end
            CAPTURE: begin
                if (!enable) begin
                    state_next = IDLE;
                    cnt_next   = 16'd0;
                end else if (strobe) begin
                    if (cnt == 16'd1) begin
                        state_next  = IDLE;
                        cnt_next    = 16'd0;
                        window_done = 1'b1;
                    end else begin
                        cnt_next = cnt - 16'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 16'd0;
            end
        endcase

        // A rise seen in the cycle a window ends still counts as missed:
        // the machine was busy when it arrived.
        missed_next       = missed_trigger || (trig_rise && (state != IDLE));
        window_count_next = window_count + {15'd0, window_done};
        if (clear) begin
            missed_next       = 1'b0;
            window_count_next = 16'd0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= 16'd0;
            len_lat        <= 16'd0;
            gate_out       <= 1'b0;
            busy           <= 1'b0;
            missed_trigger <= 1'b0;
            window_count   <= 16'd0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            len_lat        <= len_lat_next;
            gate_out       <= (state_next == CAPTURE);
            busy           <= (state_next != IDLE);
            missed_trigger <= missed_next;
            window_count   <= window_count_next;
        end
    end

    assign status    = {14'b0, enable, missed_trigger, window_count};
    assign state_dbg = state;

endmodule

// File: tb/tb_rx_gate_sequencer.sv
// tb_rx_gate_sequencer
//
// Directed sequence with randomized strobe spacing and trigger hold times.
// Expected gate/busy values come from strobe arithmetic: with s strobes
// counted since acceptance, the gate is high for d <= s < d+l and the
// window is busy for s < d+l.

module tb_rx_gate_sequencer;

    localparam logic [6:0] ADDR_DELAY  = 7'd64;
    localparam logic [6:0] ADDR_LENGTH = 7'd65;
    localparam logic [6:0] ADDR_CTRL   = 7'd66;

    logic        clock         = 1'b0;
    logic        reset_n       = 1'b0;
    logic        serial_strobe = 1'b0;
    logic [6:0]  serial_addr   = 7'd0;
    logic [31:0] serial_data   = 32'd0;
    logic        trigger       = 1'b0;
    logic        strobe        = 1'b0;
    logic        gate_out;
    logic        busy;
    logic        missed_trigger;
    logic [15:0] window_count;
    logic [31:0] status;
    logic [1:0]  state_dbg;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] exp_count  = 16'd0;
    logic        exp_missed = 1'b0;
    logic        exp_enable = 1'b0;
    logic [15:0] exp_q[$];

    rx_gate_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .serial_strobe  (serial_strobe),
        .serial_addr    (serial_addr),
        .serial_data    (serial_data),
        .trigger        (trigger),
        .strobe         (strobe),
        .gate_out       (gate_out),
        .busy           (busy),
        .missed_trigger (missed_trigger),
        .window_count   (window_count),
        .status         (status),
        .state_dbg      (state_dbg)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drivers: inputs change on the falling edge, outputs sampled 1 time
    // unit after the rising edge.
    task automatic tick(input logic trg, input logic stb);
        @(negedge clock);
        trigger = trg;
        strobe  = stb;
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [6:0] addr, input logic [31:0] data);
        @(negedge clock);
        serial_strobe = 1'b1;
        serial_addr   = addr;
        serial_data   = data;
        strobe        = 1'b0;
        @(posedge clock);
        #1;
        serial_strobe = 1'b0;
        if (addr == ADDR_CTRL) begin
            exp_enable = data[0];
            if (data[1]) begin
                exp_missed = 1'b0;
                exp_count  = 16'd0;
            end
        end
    endtask

    task automatic write_val(input logic [6:0] addr, input logic [15:0] val);
        logic [15:0] junk;
        junk = 16'($urandom_range(0, 65535));
        write_reg(addr, {junk, val});
    endtask

    task automatic check_window(input int s, input int d, input int l);
        check("gate", {31'd0, gate_out}, {31'd0, (s >= d) && (s < d + l)});
        check("busy", {31'd0, busy}, {31'd0, s < d + l});
        check("missed", {31'd0, missed_trigger}, {31'd0, exp_missed});
    endtask

    // One complete window. period==0 gives random strobes, otherwise a
    // strobe every period-th clock. retrig_at/wr_at (>=0) insert a second
    // trigger rise or a length write once s strobes have been counted.
    task automatic run_window(input int d, input int l, input int period,
                              input int retrig_at, input int wr_at,
                              input logic [15:0] wr_val);
        int s, t, hold;
        bit stb, trg, retrig_done, wr_done;
        s = 0; t = 0;
        hold = $urandom_range(1, 4);
        retrig_done = 0; wr_done = 0;
        tick(1'b1, 1'b0);
        check_window(s, d, l);
        while (s < d + l) begin
            if (t > 1000) begin
                check("window_timeout", s, d + l);
                break;
            end
            if (!retrig_done && retrig_at >= 0 && s == retrig_at) begin
                tick(1'b0, 1'b0);
                check_window(s, d, l);
                tick(1'b1, 1'b0);
                exp_missed = 1'b1;
                check_window(s, d, l);
                retrig_done = 1;
            end else if (!wr_done && wr_at >= 0 && s == wr_at) begin
                write_val(ADDR_LENGTH, wr_val);
                wr_done = 1;
                check_window(s, d, l);
            end else begin
                if (period == 0) stb = 1'($urandom_range(0, 1));
                else             stb = ((t % period) == period - 1);
                trg = retrig_done ? 1'b1 : (t < hold);
                tick(trg, stb);
                if (stb) begin
                    s++;
                    if (s == d + l) begin
                        exp_count++;
                        exp_q.push_back(exp_count);
                    end
                end
                check_window(s, d, l);
            end
            t++;
        end
        tick(1'b0, 1'b0);
        check("gate_after", {31'd0, gate_out}, 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
        if (exp_q.size() > 0)
            check("window_count", {16'd0, window_count}, {16'd0, exp_q.pop_front()});
    endtask

    // Directed sequence
    initial begin
        int d, l;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_gate", {31'd0, gate_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_missed", {31'd0, missed_trigger}, 32'd0);
        check("rst_count", {16'd0, window_count}, 32'd0);
        check("rst_status", status, 32'd0);
        reset_n = 1'b1;
        tick(1'b0, 1'b0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);

        // Basic window: delay 3, length 5, strobe every 4th clock
        write_val(ADDR_DELAY, 16'd3);
        write_val(ADDR_LENGTH, 16'd5);
        write_reg(ADDR_CTRL, 32'h1);
        run_window(3, 5, 4, -1, -1, 16'd0);
        check("status_basic", status, {14'b0, exp_enable, exp_missed, exp_count});

        // Zero-delay latency
        write_val(ADDR_DELAY, 16'd0);
        write_val(ADDR_LENGTH, 16'd2);
        run_window(0, 2, 0, -1, -1, 16'd0);

        // Retrigger during capture; window keeps its 10 strobes
        d = $urandom_range(1, 2);
        write_val(ADDR_DELAY, 16'(d));
        write_val(ADDR_LENGTH, 16'd10);
        run_window(d, 10, 0, d + 2, -1, 16'd0);
        check("missed_set", {31'd0, missed_trigger}, 32'd1);

        // Clear status, enable stays set
        write_reg(ADDR_CTRL, 32'h3);
        check("clr_missed", {31'd0, missed_trigger}, 32'd0);
        check("clr_count", {16'd0, window_count}, 32'd0);
        check("clr_status", status, {14'b0, exp_enable, exp_missed, exp_count});

        // Window end coinciding with a new rise: IDLE, flag set, no restart
        write_val(ADDR_DELAY, 16'd0);
        write_val(ADDR_LENGTH, 16'd1);
        tick(1'b1, 1'b0);
        check("coin_gate0", {31'd0, gate_out}, 32'd1);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        exp_missed = 1'b1;
        exp_count++;
        check("coin_gate", {31'd0, gate_out}, 32'd0);
        check("coin_busy", {31'd0, busy}, 32'd0);
        check("coin_missed", {31'd0, missed_trigger}, 32'd1);
        check("coin_count", {16'd0, window_count}, {16'd0, exp_count});
        tick(1'b1, 1'b0);
        check("coin_norestart", {31'd0, busy}, 32'd0);
        tick(1'b0, 1'b0);
        write_reg(ADDR_CTRL, 32'h3);

        // Length rewritten mid-window: current window keeps 8, next uses 1
        d = $urandom_range(0, 2);
        write_val(ADDR_DELAY, 16'(d));
        write_val(ADDR_LENGTH, 16'd8);
        run_window(d, 8, 0, -1, d + 3, 16'd1);
        run_window(d, 1, 0, -1, -1, 16'd0);

        // Enable cleared mid-window
        write_val(ADDR_DELAY, 16'd0);
        write_val(ADDR_LENGTH, 16'd8);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        write_reg(ADDR_CTRL, 32'h0);
        check("dis_gate_hold", {31'd0, gate_out}, 32'd1);
        tick(1'b0, 1'b0);
        check("dis_gate", {31'd0, gate_out}, 32'd0);
        check("dis_busy", {31'd0, busy}, 32'd0);
        check("dis_count", {16'd0, window_count}, {16'd0, exp_count});

        // Trigger while disabled: ignored, no flag
        tick(1'b1, 1'b0);
        check("off_busy", {31'd0, busy}, 32'd0);
        check("off_missed", {31'd0, missed_trigger}, {31'd0, exp_missed});
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        check("off_gate", {31'd0, gate_out}, 32'd0);

        // Zero length: ignored, no flag
        write_val(ADDR_LENGTH, 16'd0);
        write_reg(ADDR_CTRL, 32'h1);
        tick(1'b1, 1'b0);
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_missed", {31'd0, missed_trigger}, 32'd0);
        tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        check("len0_gate", {31'd0, gate_out}, 32'd0);

        // Random windows
        for (int i = 0; i < 6; i++) begin
            int r;
            d = $urandom_range(0, 4);
            l = $urandom_range(1, 6);
            write_val(ADDR_DELAY, 16'(d));
            write_val(ADDR_LENGTH, 16'(l));
            r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, d + l - 1)) : -1;
            run_window(d, l, 0, r, -1, 16'd0);
        end

        // Counter wrap: preload 16'hFFFF completed windows
        force dut.window_count = 16'hFFFF;
        tick(1'b0, 1'b0);
        release dut.window_count;
        exp_count = 16'hFFFF;
        tick(1'b0, 1'b0);
        check("preload", {16'd0, window_count}, 32'h0000FFFF);
        write_val(ADDR_DELAY, 16'd0);
        write_val(ADDR_LENGTH, 16'd1);
        run_window(0, 1, 0, -1, -1, 16'd0);
        check("wrap", {16'd0, window_count}, 32'd0);
        run_window(0, 1, 0, -1, -1, 16'd0);

        // Asynchronous reset in the middle of a capture
        write_val(ADDR_LENGTH, 16'd10);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        exp_missed = 1'b1;
        check("pre_rst_gate", {31'd0, gate_out}, 32'd1);
        check("pre_rst_missed", {31'd0, missed_trigger}, 32'd1);
        check("pre_rst_count", {16'd0, window_count}, {16'd0, exp_count});
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_gate", {31'd0, gate_out}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_missed", {31'd0, missed_trigger}, 32'd0);
        check("arst_count", {16'd0, window_count}, 32'd0);
        check("arst_status", status, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        trigger = 1'b0;
        tick(1'b0, 1'b0);
        check("arst_state", {30'd0, state_dbg}, 32'd0);
        check("arst_busy_after", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
